// File: rtl/gpio_button_irq_pkg.sv
// gpio_button_irq_pkg: edge-mode encoding and edge qualification shared by the button block
package gpio_button_irq_pkg;
  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;
  function automatic logic edge_match(input logic [1:0] mode, input logic lvl);
    return mode == EDGE_BOTH || mode == (lvl ? EDGE_RISE : EDGE_FALL);
  endfunction
endpackage

// File: rtl/gpio_button_irq_btn_debounce.sv
// gpio_button_irq_btn_debounce: per-pin synchroniser and debouncer with a one-cycle change pulse
module gpio_button_irq_btn_debounce #(
  parameter int DEBOUNCE_CYC = 50000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic sys_clk,
  input  logic rst_sync,
  input  logic pin_i,
  output logic level_o,
  output logic pulse_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic stable_q, pulse_q, s, accept;
  assign s = sync_q[SYNC_STAGES-1];
  assign accept = (s != stable_q) && (cnt_q == CNT_MAX);
  // any return to the stable level restarts the count, so short glitches never accumulate
  assign cnt_d = (s == stable_q || accept) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge sys_clk) begin
    if (!rst_sync) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pin_i};
      cnt_q    <= cnt_d;
      stable_q <= accept ? s : stable_q;
      pulse_q  <= accept;
    end
  end
  assign level_o = stable_q;
  assign pulse_o = pulse_q;
endmodule

// File: rtl/gpio_button_irq.sv
// gpio_button_irq: debounced button channels with edge-qualified pending bits and a registered irq
module gpio_button_irq
  import gpio_button_irq_pkg::*;
#(
  parameter int N_CH         = 3,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              sys_clk,
  input  logic              rst_sync,
  input  logic [N_CH-1:0]   btn_in,
  input  logic [2*N_CH-1:0] edge_mode,
  input  logic              clr_en,
  input  logic [N_CH-1:0]   clr_mask,
  output logic [N_CH-1:0]   btn_level,
  output logic [N_CH-1:0]   edge_pulse,
  output logic [N_CH-1:0]   pending,
  output logic              irq
);
  logic [N_CH-1:0] set, pending_d, pending_q;
  logic irq_q;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    gpio_button_irq_btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_db (
      .sys_clk (sys_clk),
      .rst_sync(rst_sync),
      .pin_i   (btn_in[i]),
      .level_o (btn_level[i]),
      .pulse_o (edge_pulse[i])
    );
    assign set[i] = edge_pulse[i] && edge_match(edge_mode[2*i+:2], btn_level[i]);
  end
  // set is OR-ed in after the clear so a coincident edge is never lost
  assign pending_d = (pending_q & ~(clr_en ? clr_mask : '0)) | set;
  always_ff @(posedge sys_clk) begin
    if (!rst_sync) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      irq_q     <= |pending_q;
    end
  end
  assign pending = pending_q;
  assign irq     = irq_q;
endmodule
